// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with round-robin fairness and a full-memory
// clear sequencer that walks every address writing zero.
module mem_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_in,
  output logic       mem_we,
  input  logic [7:0] mem_out
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       last_b;
  logic       open;
  logic       clearing;

  assign open     = (state == IDLE) & ~rst & ~clr_start;
  assign clearing = (state == CLEAR) & ~rst;

  // A wins a tie only if B held the last grant
  assign a_gnt = open & a_req & (~b_req | last_b);
  assign b_gnt = open & b_req & ~a_gnt;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = 8'h00;
    mem_in   = 8'h00;
    unique case (1'b1)
      clearing: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
      end
      a_gnt: begin
        mem_we   = a_we;
        mem_addr = a_addr;
        mem_in   = a_wdata;
      end
      b_gnt: begin
        mem_we   = b_we;
        mem_addr = b_addr;
        mem_in   = b_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'h00;
      last_b   <= 1'b1;
      clr_busy <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= 8'h00;
      b_rdata  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            cnt      <= 8'h00;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 8'h01;
          if (cnt == 8'hff) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
      endcase
      if (a_gnt) last_b <= 1'b0;
      if (b_gnt) last_b <= 1'b1;
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt & ~a_we) a_rdata <= mem_out;
      if (b_gnt & ~b_we) b_rdata <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       clr_start, clr_busy;
  logic [7:0] mem_addr, mem_in, mem_out;
  logic       mem_we;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we),
    .mem_out(mem_out)
  );

  // One lone access; ends at the negedge after the grant cycle
  task automatic access(input bit use_b, input bit we,
                        input logic [7:0] addr, input logic [7:0] wd,
                        output bit gnt, output bit rv,
                        output logic [7:0] rd);
    @(negedge clk);
    if (use_b) begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    #1;
    gnt = use_b ? b_gnt : a_gnt;
    @(negedge clk);
    a_req = 0; b_req = 0;
    rv = use_b ? b_rvalid : a_rvalid;
    rd = use_b ? b_rdata : a_rdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    #1;
    checks++;
    if (a_gnt !== 0 || b_gnt !== 0 || mem_we !== 0) begin
      errors++;
      $display("FAIL rst_force gnt=%b%b we=%b need 000", a_gnt, b_gnt, mem_we);
    end
    @(negedge clk);
    rst = 0; a_req = 0; b_req = 0;
    checks++;
    if (clr_busy !== 0 || a_rvalid !== 0 || b_rvalid !== 0 ||
        a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_state busy=%b rv=%b%b rd=%h/%h need 0 00 00/00",
               clr_busy, a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    #1;
    checks++;
    if (mem_we !== 0 || mem_addr !== 8'h00 || mem_in !== 8'h00) begin
      errors++;
      $display("FAIL idle_mem we=%b addr=%h in=%h need 0/00/00",
               mem_we, mem_addr, mem_in);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5a;
    #1;
    checks++;
    if (a_gnt !== 1 || b_gnt !== 0 || mem_we !== 1 ||
        mem_addr !== 8'h10 || mem_in !== 8'h5a) begin
      errors++;
      $display("FAIL wr_grant gnt=%b%b we=%b a=%h d=%h need 10 1 10 5a",
               a_gnt, b_gnt, mem_we, mem_addr, mem_in);
    end
    @(negedge clk);
    a_req = 0; b_req = 1; b_we = 0; b_addr = 8'h10;
    #1;
    checks++;
    if (b_gnt !== 1 || a_gnt !== 0 || mem_we !== 0 || a_rvalid !== 0) begin
      errors++;
      $display("FAIL rd_grant gnt=%b%b we=%b arv=%b need 01 0 0",
               a_gnt, b_gnt, mem_we, a_rvalid);
    end
    @(negedge clk);
    b_req = 0;
    checks++;
    if (b_rvalid !== 1 || b_rdata !== 8'h5a) begin
      errors++;
      $display("FAIL rd_data rv=%b rd=%h need 1 5a", b_rvalid, b_rdata);
    end
    @(negedge clk);
    checks++;
    if (b_rvalid !== 0 || b_rdata !== 8'h5a) begin
      errors++;
      $display("FAIL rd_hold rv=%b rd=%h need 0 5a", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    a_req = 1; a_we = 0; a_addr = 8'h10;
    b_req = 1; b_we = 0; b_addr = 8'h30;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1) ||
          a_rvalid !== (k % 2 == 1) || b_rvalid !== (k >= 2 && k % 2 == 0)) begin
        errors++;
        $display("FAIL contend%0d gnt=%b%b rv=%b%b", k,
                 a_gnt, b_gnt, a_rvalid, b_rvalid);
      end
      @(negedge clk);
    end
    a_req = 0; b_req = 0;
    checks++;
    if (b_rvalid !== 1 || b_rdata !== 8'hcf || a_rdata !== 8'h5a) begin
      errors++;
      $display("FAIL contend_data brv=%b b=%h a=%h need 1 cf 5a",
               b_rvalid, b_rdata, a_rdata);
    end
  endtask

  task automatic test_clear();
    bit g, rv;
    logic [7:0] rd;
    int n;
    access(0, 1, 8'h00, 8'hff, g, rv, rd);
    access(1, 1, 8'hff, 8'hff, g, rv, rd);
    @(negedge clk);
    clr_start = 1; a_req = 1; a_we = 0; a_addr = 8'h00;
    #1;
    checks++;
    if (a_gnt !== 0 || b_gnt !== 0) begin
      errors++;
      $display("FAIL clr_start_block gnt=%b%b need 00", a_gnt, b_gnt);
    end
    @(negedge clk);
    clr_start = 0;
    #1;
    checks++;
    if (mem_we !== 1 || mem_addr !== 8'h00 || mem_in !== 8'h00) begin
      errors++;
      $display("FAIL clr_first we=%b a=%h d=%h need 1 00 00",
               mem_we, mem_addr, mem_in);
    end
    n = 0;
    while (clr_busy === 1 && n < 400) begin
      clr_start = (n == 100);
      #1;
      checks++;
      if (a_gnt !== 0 || b_gnt !== 0 || mem_addr !== n[7:0]) begin
        errors++;
        $display("FAIL clr_cycle%0d gnt=%b%b a=%h", n, a_gnt, b_gnt, mem_addr);
      end
      n++;
      @(negedge clk);
    end
    clr_start = 0;
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL clr_len got %0d need 256", n);
    end
    #1;
    checks++;
    if (a_gnt !== 1) begin
      errors++;
      $display("FAIL clr_after_gnt a_gnt=%b need 1", a_gnt);
    end
    @(negedge clk);
    a_req = 0;
    checks++;
    if (a_rvalid !== 1 || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL clr_rd00 rv=%b rd=%h need 1 00", a_rvalid, a_rdata);
    end
    access(1, 0, 8'hff, 8'h00, g, rv, rd);
    checks++;
    if (g !== 1 || rv !== 1 || rd !== 8'h00) begin
      errors++;
      $display("FAIL clr_rdff g=%b rv=%b rd=%h need 1 1 00", g, rv, rd);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit g, rv;
    logic [7:0] rd;
    access(1, 1, 8'h20, 8'h77, g, rv, rd);
    access(0, 1, 8'h03, 8'h33, g, rv, rd);
    access(0, 1, 8'h09, 8'h99, g, rv, rd);
    access(1, 1, 8'h0a, 8'ha0, g, rv, rd);
    @(negedge clk);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (clr_busy !== 0) begin
      errors++;
      $display("FAIL abort_busy got %b need 0", clr_busy);
    end
    access(0, 0, 8'h03, 8'h00, g, rv, rd);
    checks++;
    if (rd !== 8'h00 || rv !== 1) begin
      errors++;
      $display("FAIL abort_rd03 rv=%b rd=%h need 1 00", rv, rd);
    end
    access(1, 0, 8'h09, 8'h00, g, rv, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL abort_rd09 got %h need 00", rd);
    end
    access(0, 0, 8'h0a, 8'h00, g, rv, rd);
    checks++;
    if (rd !== 8'ha0) begin
      errors++;
      $display("FAIL abort_rd0a got %h need a0", rd);
    end
    access(1, 0, 8'h20, 8'h00, g, rv, rd);
    checks++;
    if (rd !== 8'h77) begin
      errors++;
      $display("FAIL abort_rd20 got %h need 77", rd);
    end
  endtask

  task automatic test_read_then_reset();
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h20;
    #1;
    checks++;
    if (a_gnt !== 1) begin
      errors++;
      $display("FAIL rr_gnt got %b need 1", a_gnt);
    end
    @(negedge clk);
    a_req = 0; rst = 1;
    checks++;
    if (a_rvalid !== 1 || a_rdata !== 8'h77) begin
      errors++;
      $display("FAIL rr_pre rv=%b rd=%h need 1 77", a_rvalid, a_rdata);
    end
    @(negedge clk);
    rst = 0;
    checks++;
    if (a_rvalid !== 0 || a_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rr_post rv=%b rd=%h need 0 00", a_rvalid, a_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
    rst = 1; clr_start = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    test_reset();
    test_write_read();
    test_contention();
    test_clear();
    test_reset_mid_clear();
    test_read_then_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
